// File: rtl/cache_ctrl_sa_pkg.sv
// Shared types for the set-associative cache tag/state controller: command and
// bus-op encodings, controller states, per-line metadata and the line-address helper.
package cache_ctrl_sa_pkg;

   localparam int MAX_ADDR_W = 64;

   typedef enum logic [2:0] {
      RESET      = 3'd0,
      INVALIDATE = 3'd1,
      READ       = 3'd2,
      WRITE      = 3'd3
   } inst_t;

   typedef enum logic [1:0] {
      NOP       = 2'd0,
      READ_OUT  = 2'd1,
      WRITE_OUT = 2'd2,
      RW_OUT    = 2'd3
   } output_t;

   typedef enum logic [1:0] {
      CLEAR,
      IDLE,
      LOOKUP
   } ctrl_state_t;

   // Tag is held zero-extended to the widest supported address so the struct
   // does not depend on the controller's parameters.
   typedef struct packed {
      logic                  valid;
      logic                  dirty;
      logic [MAX_ADDR_W-1:0] tag;
   } line_meta_t;

   function automatic logic [MAX_ADDR_W-1:0] line_addr(
      input logic [MAX_ADDR_W-1:0] tag,
      input logic [MAX_ADDR_W-1:0] index,
      input int                    off_w,
      input int                    idx_w
   );
      return (tag << (off_w + idx_w)) | (index << off_w);
   endfunction

endpackage

// File: rtl/cache_ctrl_sa_lru.sv
// True-LRU age update for one set: promotes the accessed way to age 0 and
// reports the way currently holding the oldest age.
module cache_lru_update #(
   parameter  int NUM_WAYS = 4,
   localparam int WAY_W    = $clog2(NUM_WAYS)
) (
   input  logic [NUM_WAYS-1:0][WAY_W-1:0] ages,
   input  logic [WAY_W-1:0]               acc_way,
   output logic [NUM_WAYS-1:0][WAY_W-1:0] new_ages,
   output logic [WAY_W-1:0]               lru_way
);

   always_comb begin
      lru_way = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (ages[w] == WAY_W'(NUM_WAYS - 1)) lru_way = WAY_W'(w);
      end
   end

   always_comb begin
      new_ages = ages;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (WAY_W'(w) == acc_way)         new_ages[w] = '0;
         else if (ages[w] < ages[acc_way]) new_ages[w] = ages[w] + 1'b1;
      end
   end

endmodule

// File: rtl/cache_ctrl_sa.sv
// Set-associative write-back/write-allocate cache tag controller, one bus op per command.
// Define CACHE_STATS_EN to implement the saturating hit/miss counters (tied to 0 otherwise).
//
// state  | meaning
// CLEAR  | sweeping one set per cycle: invalidate lines, reset ages to way index
// IDLE   | ready for a command
// LOOKUP | registered command resolved; arrays and response update at the edge
module cache_ctrl_sa
   import cache_ctrl_sa_pkg::*;
#(
   parameter  int ADDR_W     = 32,
   parameter  int LINE_BYTES = 64,
   parameter  int NUM_SETS   = 16,
   parameter  int NUM_WAYS   = 4,
   parameter  int CNT_W      = 32,
   localparam int WAY_W      = $clog2(NUM_WAYS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  inst_t             cmd_inst,
   input  logic [ADDR_W-1:0] cmd_addr,
   output logic              rsp_valid,
   output logic              rsp_hit,
   output output_t           rsp_bus_op,
   output logic [ADDR_W-1:0] rsp_wb_addr,
   output logic [ADDR_W-1:0] rsp_fill_addr,
   output logic [WAY_W-1:0]  rsp_way,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   localparam int OFF_W = $clog2(LINE_BYTES);
   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

   ctrl_state_t state_q, state_d;
   logic [IDX_W-1:0] sweep_q, idx_q;
   logic [TAG_W-1:0] tag_q;
   inst_t            inst_q;
   logic             clr_rsp_q;

   line_meta_t                     meta_q [NUM_SETS][NUM_WAYS];
   logic [NUM_WAYS-1:0][WAY_W-1:0] age_q  [NUM_SETS];
   logic [NUM_WAYS-1:0][WAY_W-1:0] set_age, new_age;

   logic                  hit, any_inv, is_access;
   logic [WAY_W-1:0]      hit_way, inv_way, lru_way, victim, acc_way;
   line_meta_t            vic_meta;
   logic [MAX_ADDR_W-1:0] tag_ext;

   logic              rsp_hit_d;
   output_t           op_d;
   logic [ADDR_W-1:0] wb_d, fill_d;
   logic [WAY_W-1:0]  way_d;

   logic unused_off;
   assign unused_off = ^cmd_addr[OFF_W-1:0];

   assign cmd_ready = (state_q == IDLE) && !reset;
   assign set_age   = age_q[idx_q];
   assign is_access = (inst_q == READ) || (inst_q == WRITE);

   // Descending scan so the lowest matching index wins.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      any_inv = 1'b0;
      inv_way = '0;
      tag_ext = MAX_ADDR_W'(tag_q);
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (!meta_q[idx_q][w].valid) begin
            any_inv = 1'b1;
            inv_way = WAY_W'(w);
         end
         if (meta_q[idx_q][w].valid && (meta_q[idx_q][w].tag == tag_ext)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
      victim   = any_inv ? inv_way : lru_way;
      vic_meta = meta_q[idx_q][victim];
      acc_way  = hit ? hit_way : victim;
   end

   cache_lru_update #(.NUM_WAYS(NUM_WAYS)) u_lru (
      .ages     (set_age),
      .acc_way  (acc_way),
      .new_ages (new_age),
      .lru_way  (lru_way)
   );

   always_comb begin
      rsp_hit_d = 1'b0;
      op_d      = NOP;
      wb_d      = '0;
      fill_d    = '0;
      way_d     = '0;
      if (is_access) begin
         rsp_hit_d = hit;
         way_d     = acc_way;
         if (!hit) begin
            fill_d = ADDR_W'(line_addr(tag_ext, MAX_ADDR_W'(idx_q), OFF_W, IDX_W));
            if (vic_meta.valid && vic_meta.dirty) begin
               op_d = RW_OUT;
               wb_d = ADDR_W'(line_addr(vic_meta.tag, MAX_ADDR_W'(idx_q), OFF_W, IDX_W));
            end else begin
               op_d = READ_OUT;
            end
         end
      end else if (inst_q == INVALIDATE) begin
         rsp_hit_d = hit;
         if (hit) begin
            way_d = hit_way;
            if (meta_q[idx_q][hit_way].dirty) begin
               op_d = WRITE_OUT;
               wb_d = ADDR_W'(line_addr(tag_ext, MAX_ADDR_W'(idx_q), OFF_W, IDX_W));
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         CLEAR:   if (sweep_q == IDX_W'(NUM_SETS - 1)) state_d = IDLE;
         IDLE:    if (cmd_valid) state_d = LOOKUP;
         LOOKUP:  state_d = (inst_q == RESET) ? CLEAR : IDLE;
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= CLEAR;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sweep_q       <= '0;
         clr_rsp_q     <= 1'b0;
         inst_q        <= RESET;
         idx_q         <= '0;
         tag_q         <= '0;
         rsp_valid     <= 1'b0;
         rsp_hit       <= 1'b0;
         rsp_bus_op    <= NOP;
         rsp_wb_addr   <= '0;
         rsp_fill_addr <= '0;
         rsp_way       <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state_q)
            CLEAR: begin
               sweep_q <= sweep_q + 1'b1;
               if (sweep_q == IDX_W'(NUM_SETS - 1)) begin
                  clr_rsp_q <= 1'b0;
                  if (clr_rsp_q) begin
                     rsp_valid     <= 1'b1;
                     rsp_hit       <= 1'b0;
                     rsp_bus_op    <= NOP;
                     rsp_wb_addr   <= '0;
                     rsp_fill_addr <= '0;
                     rsp_way       <= '0;
                  end
               end
            end
            IDLE: begin
               if (cmd_valid) begin
                  inst_q <= cmd_inst;
                  idx_q  <= cmd_addr[OFF_W+IDX_W-1:OFF_W];
                  tag_q  <= cmd_addr[ADDR_W-1:OFF_W+IDX_W];
               end
            end
            LOOKUP: begin
               // A RESET command answers only once its sweep completes.
               if (inst_q == RESET) begin
                  clr_rsp_q <= 1'b1;
               end else begin
                  rsp_valid     <= 1'b1;
                  rsp_hit       <= rsp_hit_d;
                  rsp_bus_op    <= op_d;
                  rsp_wb_addr   <= wb_d;
                  rsp_fill_addr <= fill_d;
                  rsp_way       <= way_d;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state_q == CLEAR) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
               meta_q[sweep_q][w].valid <= 1'b0;
               meta_q[sweep_q][w].dirty <= 1'b0;
               age_q[sweep_q][w]        <= WAY_W'(w);
            end
         end else if (state_q == LOOKUP) begin
            if (is_access) begin
               age_q[idx_q] <= new_age;
               if (hit) begin
                  if (inst_q == WRITE) meta_q[idx_q][hit_way].dirty <= 1'b1;
               end else begin
                  meta_q[idx_q][victim] <= line_meta_t'{valid: 1'b1,
                                                        dirty: (inst_q == WRITE),
                                                        tag:   tag_ext};
               end
            end else if ((inst_q == INVALIDATE) && hit) begin
               meta_q[idx_q][hit_way].valid <= 1'b0;
               meta_q[idx_q][hit_way].dirty <= 1'b0;
            end
         end
      end
   end

`ifdef CACHE_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (state_q == LOOKUP) begin
         if (inst_q == RESET) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
         end else if (is_access) begin
            if (hit) begin
               if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            end else begin
               if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            end
         end
      end
   end
`else
   assign hit_cnt  = '0;
   assign miss_cnt = '0;
`endif

endmodule
